dram_access_ctrl: RTL and testbench

- Processor-side initiator for the downsampling data memory.
- Sequences the memory's image-load handshake, then serves single-byte load/store requests from the processor core.
- On the core's finish request, sequences the memory's result write-back handshake.
- Converts the memory's level-sensitive read/write strobes and registered read data into a valid/ready request port and a one-cycle response pulse.
- Adds timeout detection on both done handshakes.

---
 rtl/dram_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dram_access_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_access_ctrl.sv
// Purpose : processor-side initiator for the downsampling data memory. It runs the
//           image-load handshake, serves single-byte load/store requests through a
//           valid/ready port, runs the result write-back handshake, and flags timeouts.
// Ports   : clk/rst (async active-high); start/finish control pulses;
//           req_* request port with req_ready; resp_valid/resp_rdata load response;
//           busy/done/err status; mem_* registered strobes/address/data to the memory,
//           with mem_dout/mem_rd_done/mem_wr_done returned by it.
// Latency : a store strobe appears 1 cycle after accept; load data appears 3 cycles after accept.
module dram_access_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_rd_done,
  input  logic              mem_wr_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The count held during the last permitted waiting cycle; reaching it without a
  // done means TIMEOUT cycles have elapsed in the waiting state.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READY, S_RD_ISSUE, S_RD_CAPT, S_FLUSH, S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_done;
  logic              r_err;
  logic              r_mem_rd_en;
  logic              r_mem_wr_en;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;

  logic              w_accept;
  logic              w_timeout;
  logic              w_resp_valid;
  logic [DATA_W-1:0] w_resp_rdata;
  logic              w_done;
  logic              w_err;
  logic              w_mem_rd_en;
  logic              w_mem_wr_en;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_din;

  assign w_accept  = (r_state == S_READY) && req_valid;
  assign w_timeout = (r_cnt == TO_LAST);

  // State register and wait counter. The counter only advances while waiting on a
  // done handshake and restarts from zero whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (((r_state == S_LOAD) || (r_state == S_FLUSH)) && (r_cnt != TO_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic. In READY an accepted request takes priority over finish,
  // which is then simply dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_LOAD;
      S_LOAD: begin
        if (mem_rd_done)    w_next = S_READY;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_READY: begin
        if (w_accept && !req_we)  w_next = S_RD_ISSUE;
        else if (!w_accept && finish) w_next = S_FLUSH;
      end
      S_RD_ISSUE: w_next = S_RD_CAPT;
      S_RD_CAPT:  w_next = S_READY;
      S_FLUSH: begin
        if (mem_wr_done)    w_next = S_IDLE;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_ERROR:    w_next = S_ERROR;
      default:    w_next = S_IDLE;
    endcase
  end

  // Output logic: direct status decodes plus the next values of every registered output.
  always_comb begin
    req_ready    = (r_state == S_READY);
    busy         = (r_state != S_IDLE);
    // Handshake enables follow the state being entered, so they drop on the same
    // edge that sees the done (or the timeout).
    w_mem_rd_en  = (w_next == S_LOAD);
    w_mem_wr_en  = (w_next == S_FLUSH);
    w_mem_write  = w_accept && req_we;
    w_mem_read   = w_accept && !req_we;
    w_mem_addr   = w_accept ? req_addr : r_mem_addr;
    w_mem_din    = (w_accept && req_we) ? req_wdata : r_mem_din;
    // The memory registers its read data, so mem_dout is valid during RD_CAPT.
    w_resp_valid = (r_state == S_RD_CAPT);
    w_resp_rdata = (r_state == S_RD_CAPT) ? mem_dout : r_resp_rdata;
    w_done       = (r_state == S_FLUSH) && mem_wr_done;
    if (w_next == S_ERROR)                 w_err = 1'b1;
    else if ((r_state == S_IDLE) && start) w_err = 1'b0;
    else                                   w_err = r_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_mem_wr_en  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
    end else begin
      r_resp_valid <= w_resp_valid;
      r_resp_rdata <= w_resp_rdata;
      r_done       <= w_done;
      r_err        <= w_err;
      r_mem_rd_en  <= w_mem_rd_en;
      r_mem_wr_en  <= w_mem_wr_en;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_mem_addr   <= w_mem_addr;
      r_mem_din    <= w_mem_din;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign done       = r_done;
  assign err        = r_err;
  assign mem_rd_en  = r_mem_rd_en;
  assign mem_wr_en  = r_mem_wr_en;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Purpose : self-checking bench for dram_access_ctrl with a registered-read memory model.
// Ports   : none (top-level bench).
// Flow    : reset, directed handshake/store/load/finish/timeout/reset sequences, then random traffic.
module tb_dram_access_ctrl;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, finish, req_valid, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, resp_valid, busy, done, err;
  logic [DW-1:0] resp_rdata;
  logic          mem_rd_en, mem_wr_en, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          mem_rd_done, mem_wr_done;

  logic [DW-1:0] tb_mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  dram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_rd_done(mem_rd_done), .mem_wr_done(mem_wr_done)
  );

  always #5 clk = ~clk;

  // Memory with registered read data.
  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr] <= mem_din;
    if (mem_read)  mem_dout <= tb_mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0; finish = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rd_done = 1'b0; mem_wr_done = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic load_image();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    mem_rd_done = 1'b1;
    tick();
    mem_rd_done = 1'b0;
  endtask

  typedef struct {
    logic          v;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          e_rdy;
    logic          e_wr;
    logic          e_rd;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    logic          e_resp;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t tbl [8];

  // Reference model state for the random phase.
  logic [DW-1:0] ref_mem [16];
  int            load_age;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          st_pend;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Per-cycle vectors: request applied, then outputs expected after the edge.
    tbl[0] = '{1'b1, 1'b1, 16'h0000, 8'hD0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'hD0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 16'h0001, 8'hD1, 1'b1, 1'b1, 1'b0, 16'h0001, 8'hD1, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 16'h0002, 8'hD2, 1'b1, 1'b1, 1'b0, 16'h0002, 8'hD2, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 16'h0003, 8'hD3, 1'b1, 1'b1, 1'b0, 16'h0003, 8'hD3, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0003, 8'hD3, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 16'h0002, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0002, 8'hD3, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 16'h0009, 8'h77, 1'b0, 1'b0, 1'b0, 16'h0002, 8'hD3, 1'b0, 8'h00};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0002, 8'hD3, 1'b1, 8'hD2};

    // Reset state
    apply_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_strobes", 32'({mem_rd_en, mem_wr_en, mem_read, mem_write}), 0);
    chk("rst_flags", 32'({resp_valid, done, err}), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_din", 32'(mem_din), 0);
    chk("rst_rdata", 32'(resp_rdata), 0);

    // 1. Load handshake, done in the 5th LOAD cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("t1_rd_en_c%0d", k), 32'(mem_rd_en), 1);
      chk($sformatf("t1_busy_c%0d", k), 32'(busy), 1);
      chk($sformatf("t1_ready_c%0d", k), 32'(req_ready), 0);
      if (k == 5) mem_rd_done = 1'b1;
      tick();
    end
    mem_rd_done = 1'b0;
    chk("t1_rd_en_after", 32'(mem_rd_en), 0);
    chk("t1_ready_after", 32'(req_ready), 1);
    chk("t1_busy_after", 32'(busy), 1);

    // 2. Store then load
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1234; req_wdata = 8'hA5;
    tick();
    chk("t2_write", 32'(mem_write), 1);
    chk("t2_read0", 32'(mem_read), 0);
    chk("t2_waddr", 32'(mem_addr), 32'h1234);
    chk("t2_din", 32'(mem_din), 32'hA5);
    req_we = 1'b0; req_wdata = 8'h00;
    tick();
    req_valid = 1'b0;
    chk("t2_read", 32'(mem_read), 1);
    chk("t2_write0", 32'(mem_write), 0);
    chk("t2_raddr", 32'(mem_addr), 32'h1234);
    chk("t2_ready_c1", 32'(req_ready), 0);
    tick();
    chk("t2_resp_c2", 32'(resp_valid), 0);
    chk("t2_read_c2", 32'(mem_read), 0);
    tick();
    chk("t2_resp_c3", 32'(resp_valid), 1);
    chk("t2_rdata_c3", 32'(resp_rdata), 32'hA5);
    chk("t2_ready_c3", 32'(req_ready), 1);
    tick();
    chk("t2_resp_c4", 32'(resp_valid), 0);
    chk("t2_rdata_hold", 32'(resp_rdata), 32'hA5);

    // 3. Streaming stores and a load, table driven
    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].v; req_we = tbl[i].we; req_addr = tbl[i].a; req_wdata = tbl[i].d;
      tick();
      chk($sformatf("t3_ready_v%0d", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("t3_write_v%0d", i), 32'(mem_write), 32'(tbl[i].e_wr));
      chk($sformatf("t3_read_v%0d", i), 32'(mem_read), 32'(tbl[i].e_rd));
      chk($sformatf("t3_addr_v%0d", i), 32'(mem_addr), 32'(tbl[i].e_a));
      chk($sformatf("t3_din_v%0d", i), 32'(mem_din), 32'(tbl[i].e_d));
      chk($sformatf("t3_resp_v%0d", i), 32'(resp_valid), 32'(tbl[i].e_resp));
      if (tbl[i].e_resp) chk($sformatf("t3_rdata_v%0d", i), 32'(resp_rdata), 32'(tbl[i].e_rdata));
    end
    req_valid = 1'b0;

    // 4. Finish collides with an accepted load
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0001; finish = 1'b1;
    tick();
    req_valid = 1'b0; finish = 1'b0;
    chk("t4_read", 32'(mem_read), 1);
    chk("t4_wr_en0", 32'(mem_wr_en), 0);
    repeat (2) tick();
    chk("t4_resp", 32'(resp_valid), 1);
    chk("t4_rdata", 32'(resp_rdata), 32'hD1);
    chk("t4_ready", 32'(req_ready), 1);
    chk("t4_wr_en_still0", 32'(mem_wr_en), 0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("t4_wr_en_c%0d", k), 32'(mem_wr_en), 1);
      chk($sformatf("t4_ready_c%0d", k), 32'(req_ready), 0);
      chk($sformatf("t4_done_c%0d", k), 32'(done), 0);
      if (k == 3) mem_wr_done = 1'b1;
      tick();
    end
    mem_wr_done = 1'b0;
    chk("t4_wr_en_off", 32'(mem_wr_en), 0);
    chk("t4_done", 32'(done), 1);
    chk("t4_idle", 32'(busy), 0);
    tick();
    chk("t4_done_pulse", 32'(done), 0);

    // 5. Load timeout
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("t5_err_c%0d", k), 32'(err), 0);
      chk($sformatf("t5_rd_en_c%0d", k), 32'(mem_rd_en), 1);
    end
    tick();
    chk("t5_err", 32'(err), 1);
    chk("t5_rd_en0", 32'(mem_rd_en), 0);
    chk("t5_ready0", 32'(req_ready), 0);
    chk("t5_busy", 32'(busy), 1);
    start = 1'b1; mem_rd_done = 1'b1; req_valid = 1'b1;
    repeat (3) tick();
    start = 1'b0; mem_rd_done = 1'b0; req_valid = 1'b0;
    chk("t5_stuck_err", 32'(err), 1);
    chk("t5_stuck_busy", 32'(busy), 1);
    chk("t5_stuck_strobes", 32'({mem_rd_en, mem_wr_en, mem_read, mem_write}), 0);
    apply_reset();
    chk("t5_rst_err", 32'(err), 0);
    chk("t5_rst_busy", 32'(busy), 0);

    // 6. Asynchronous reset during RD_ISSUE
    load_image();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0003;
    tick();
    req_valid = 1'b0;
    chk("t6_read_before", 32'(mem_read), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_read_async", 32'(mem_read), 0);
    chk("t6_resp_async", 32'(resp_valid), 0);
    chk("t6_busy_async", 32'(busy), 0);
    chk("t6_addr_async", 32'(mem_addr), 0);
    #2 rst = 1'b0;
    tick();
    chk("t6_idle", 32'(busy), 0);
    chk("t6_ready", 32'(req_ready), 0);

    // Random traffic against a cycle-count reference model
    load_image();
    load_age = -1; st_pend = 1'b0; st_addr = '0; st_data = '0;
    load_addr = '0; load_data = '0;
    for (int i = 0; i < 300; i++) begin
      logic          v, we, exp_ready, acc;
      logic [3:0]    a;
      logic [DW-1:0] d;
      exp_ready = (load_age < 0) || (load_age >= 3);
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      chk("rnd_write", 32'(mem_write), 32'(st_pend));
      chk("rnd_read", 32'(mem_read), 32'(load_age == 1));
      chk("rnd_resp", 32'(resp_valid), 32'(load_age == 3));
      chk("rnd_excl", 32'({mem_read & mem_write, mem_rd_en | mem_wr_en}), 0);
      if (st_pend) begin
        chk("rnd_waddr", 32'(mem_addr), 32'(st_addr));
        chk("rnd_wdata", 32'(mem_din), 32'(st_data));
      end
      if (load_age == 1) chk("rnd_raddr", 32'(mem_addr), 32'(load_addr));
      if (load_age == 3) begin
        chk("rnd_rdata", 32'(resp_rdata), 32'(load_data));
        load_age = -1;
      end
      v  = ($urandom_range(0, 9) < 6);
      we = $urandom_range(0, 1) == 1;
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      if (i < 16) begin
        v = 1'b1; we = 1'b1; a = 4'(i);
      end
      req_valid = v; req_we = we; req_addr = {12'h010, a}; req_wdata = d;
      acc = v && exp_ready;
      st_pend = acc && we;
      if (acc && we) begin
        ref_mem[a] = d;
        st_addr = {12'h010, a};
        st_data = d;
      end
      if (acc && !we) begin
        load_age = 0;
        load_addr = {12'h010, a};
        load_data = ref_mem[a];
      end
      tick();
      if (load_age >= 0) load_age++;
    end
    req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
